// File: rtl/inst_sram_resp_pkg.sv
// Shared constants for the instruction SRAM responder: base byte address and depth.
package inst_sram_resp_pkg;

  localparam logic [31:0] INST_SRAM_BASE       = 32'h1c000000;
  localparam int          INST_SRAM_DEPTH_LOG2 = 12;

endpackage

// File: rtl/inst_sram_resp_bank.sv
// Word array for the instruction SRAM: one byte-enabled write port, one synchronous
// read port, no reset so contents survive a system reset.
module inst_sram_bank #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [3:0]            wr_be_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  rd_en_i,
  input  logic [DEPTH_LOG2-1:0] rd_addr_i,
  output logic [31:0]           rd_data_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be_i[i]) mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder: address decode, preload arbitration, read-data hold.
// Optional error flag output enabled by defining INST_SRAM_ERR_EN.
module inst_sram_resp
  import inst_sram_resp_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = INST_SRAM_BASE,
  parameter int          DEPTH_LOG2 = INST_SRAM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inst_sram_en,
  input  logic [3:0]            inst_sram_we,
  input  logic [31:0]           inst_sram_addr,
  input  logic [31:0]           inst_sram_wdata,
  output logic [31:0]           inst_sram_rdata,
  input  logic                  load_valid,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic                  load_ready
`ifdef INST_SRAM_ERR_EN
  ,output logic                 inst_sram_err
`endif
);

  logic [31:0]           offset;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  core_rd;
  logic                  core_wr;

  logic                  bank_wr_en;
  logic [3:0]            bank_wr_be;
  logic [DEPTH_LOG2-1:0] bank_wr_addr;
  logic [31:0]           bank_wr_data;
  logic                  bank_rd_en;
  logic [31:0]           bank_rd_data;

  logic                  rd_fresh_q, rd_fresh_d;
  logic [31:0]           hold_q, hold_d;

  // Unsigned subtraction makes addresses below the base wrap to huge offsets.
  assign offset   = inst_sram_addr - ADDR_BASE;
  assign in_range = (offset[31:DEPTH_LOG2+2] == '0);
  assign idx      = offset[DEPTH_LOG2+1:2];
  assign core_rd  = inst_sram_en & (inst_sram_we == 4'h0);
  assign core_wr  = inst_sram_en & (inst_sram_we != 4'h0);

  assign load_ready = load_valid & ~inst_sram_en & resetn;

  assign bank_wr_en   = resetn & ((core_wr & in_range) | load_ready);
  assign bank_wr_be   = core_wr ? inst_sram_we : 4'hF;
  assign bank_wr_addr = inst_sram_en ? idx : load_addr;
  assign bank_wr_data = inst_sram_en ? inst_sram_wdata : load_data;
  assign bank_rd_en   = resetn & core_rd & in_range;

  inst_sram_bank #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_bank (
    .clk       (clk),
    .wr_en_i   (bank_wr_en),
    .wr_be_i   (bank_wr_be),
    .wr_addr_i (bank_wr_addr),
    .wr_data_i (bank_wr_data),
    .rd_en_i   (bank_rd_en),
    .rd_addr_i (idx),
    .rd_data_o (bank_rd_data)
  );

  // The bank output is shown only in the cycle right after a read; afterwards the
  // captured copy in hold_q keeps rdata stable and lets reset force it to zero.
  always_comb begin
    hold_d     = hold_q;
    rd_fresh_d = core_rd & in_range;
    if (rd_fresh_q)           hold_d = bank_rd_data;
    if (core_rd & ~in_range)  hold_d = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_fresh_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      rd_fresh_q <= rd_fresh_d;
      hold_q     <= hold_d;
    end
  end

  assign inst_sram_rdata = rd_fresh_q ? bank_rd_data : hold_q;

`ifdef INST_SRAM_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (inst_sram_en) err_d = ~in_range | (inst_sram_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign inst_sram_err = err_q;
`endif

endmodule

// File: doc/inst_sram_resp.md
INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h1c000000, meaning the byte address of word 0.
REQ-002 SHALL have parameter DEPTH_LOG2, default 12, meaning the number of words is 2**DEPTH_LOG2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port inst_sram_en, input, 1 bit: access request this cycle.
REQ-006 SHALL have port inst_sram_we, input, 4 bits: byte-lane write enables; 4'h0 means read.
REQ-007 SHALL have port inst_sram_addr, input, 32 bits: byte address.
REQ-008 SHALL have port inst_sram_wdata, input, 32 bits: write data.
REQ-009 SHALL have port inst_sram_rdata, output, 32 bits: read data.
REQ-010 SHALL have port load_valid, input, 1 bit: preload word offered.
REQ-011 SHALL have port load_addr, input, DEPTH_LOG2 bits: preload word index.
REQ-012 SHALL have port load_data, input, 32 bits: preload word.
REQ-013 SHALL have port load_ready, output, 1 bit: preload word accepted this cycle.

Function
REQ-014 In-range test SHALL be: word index idx = (inst_sram_addr - ADDR_BASE) >> 2, using 32-bit unsigned arithmetic, and the access is in range iff idx < 2**DEPTH_LOG2.
- Wrap-around: an address below ADDR_BASE is out of range.
REQ-015 A read SHALL occur when en=1 and we=4'h0: rdata SHALL present mem[idx] exactly 1 cycle later.
REQ-016 rdata SHALL hold its last value in every cycle after a cycle with en=0, and after a write.
REQ-017 An out-of-range read SHALL return 32'h0 one cycle later.
REQ-018 A write SHALL occur when en=1 and we!=0: only the lanes with we[i]=1 SHALL update mem[idx][8i+7:8i].
REQ-019 An out-of-range write SHALL be dropped with no state change.
REQ-020 Read-during-write SHALL NOT arise, because the port is single-ported: a write does not update rdata.
REQ-021 A read of the same word in the next cycle SHALL return the merged new value.
REQ-022 addr[1:0] SHALL be ignored, so the access is word-aligned.
REQ-023 load_ready SHALL equal load_valid & ~inst_sram_en, so the core port has priority.
REQ-024 On a cycle where load_valid & load_ready, mem[load_addr] SHALL be written with load_data, all 4 bytes.
REQ-025 The preload handshake SHALL have no internal state: a stalled load_valid stays asserted until load_ready.

Reset
REQ-026 While resetn=0, inst_sram_rdata SHALL be 32'h0 and load_ready SHALL be 0.
REQ-027 Any access presented during reset SHALL be discarded, and no memory write SHALL occur.
REQ-028 Memory contents SHALL NOT be reset: they are retained across reset.
REQ-029 A read issued in the first cycle after resetn rises SHALL return data in the following cycle.
- Supports the pipeline fetching ADDR_BASE immediately after reset.

Configuration
REQ-030 Macro INST_SRAM_ERR_EN defined SHALL add an output inst_sram_err, 1 bit.
- Registered, 1-cycle latency.
- Set for an enabled access that is out of range or has addr[1:0]!=0.
- Cleared by the next enabled in-range aligned access.
- Held when en=0.
- 0 in reset.
REQ-031 With INST_SRAM_ERR_EN undefined, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 The shared header SHALL hold INST_SRAM_BASE (32'h1c000000) and INST_SRAM_DEPTH_LOG2 (12).
- These serve as the parameter defaults.
REQ-033 The word array SHALL be a sub-module inst_sram_bank: one write port with 4 byte enables, one synchronous read port, no reset.
REQ-034 inst_sram_resp SHALL hold address decode, load arbitration, rdata hold register and the error flag.

Verification
REQ-035 Preload: load words 0..3 = 32'h02800c0c, 11, 22, 33, then en=1, we=0, addr=32'h1c000008 -> rdata=32'h22 next cycle, held while en=0.
REQ-036 Byte write: we=4'b0101, wdata=32'hAABBCCDD to word 0x1c000000 holding 32'h02800c0c, then a read -> 32'h02BB0cDD; rdata is unchanged in the write's response cycle.
REQ-037 Range: a read at 32'h1bfffffc and a read at ADDR_BASE+4*4096 -> rdata=0; with INST_SRAM_ERR_EN, err=1; a following read at 32'h1c000000 clears err.
REQ-038 Arbitration: load_valid=1 with en=1 -> load_ready=0 and memory unchanged; the cycle en drops -> load_ready=1 and the word is written.
REQ-039 Reset mid-run:
- Assert resetn=0 asynchronously between edges -> rdata=0 immediately.
- A write during reset is not performed.
- After release, a read returns the pre-reset contents.
